// File: rtl/conv_window_gen_pkg.sv
// rtl/conv_window_gen_pkg.sv - shared helpers for the sliding-window generator and its CE-side users
package conv_window_gen_pkg;

    // Bit offset of channel i, window row r, window column c inside data2conv.
    function automatic int tap_offset(input int i, input int r, input int c,
                                      input int k, input int n);
        return (i * k * k + r * k + c) * n;
    endfunction

    function automatic bit kernel_legal(input int k);
        return (k == 1) || (k == 3) || (k == 5) || (k == 7);
    endfunction

    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_line_delay.sv
// rtl/conv_line_delay.sv - one raster line of pixel delay, advanced only by en
module conv_line_delay #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // Contents are deliberately not reset; the window validity gate masks stale data.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster stream to KxK window generator feeding the convolution element
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int CL_IN  = 32,
    parameter int KERNEL = 3,
    parameter int N      = 2,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CL_IN*N-1:0]                pix_in,
    input  logic                              pix_valid,
    output logic [CL_IN*KERNEL*KERNEL*N-1:0]  data2conv,
    output logic                              en_out,
    output logic                              frame_done
);

    localparam int W     = CL_IN * N;
    localparam int KK    = KERNEL * KERNEL;
    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);
    localparam int DW    = CL_IN * KK * N;

    if (!kernel_legal(KERNEL) || IMG_W < KERNEL || IMG_H < KERNEL) begin : g_bad_params
        $error("conv_window_gen: illegal KERNEL/IMG_W/IMG_H combination");
    end

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_last, row_last, pos_ok, win_valid;

    // col_in[r] is the pixel entering window row r; row KERNEL-1 is the live pixel.
    logic [W-1:0] col_in [KERNEL];
    logic [W-1:0] win_q  [KK];
    logic [W-1:0] win_d  [KK];

    logic [DW-1:0] data2conv_q, data2conv_d;
    logic          en_out_q, en_out_d;
    logic          frame_done_q, frame_done_d;

    assign col_in[KERNEL-1] = pix_in;

    for (genvar j = 0; j < KERNEL - 1; j++) begin : g_line
        conv_line_delay #(
            .W     (W),
            .DEPTH (IMG_W)
        ) u_line_delay (
            .clk  (clk),
            .en   (pix_valid),
            .din  (col_in[KERNEL-1-j]),
            .dout (col_in[KERNEL-2-j])
        );
    end

    assign col_last = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));

    if (KERNEL == 1) begin : g_pos_k1
        assign pos_ok = 1'b1;
    end else begin : g_pos_kn
        assign pos_ok = (row_q >= ROW_W'(KERNEL - 1)) && (col_q >= COL_W'(KERNEL - 1));
    end

    assign win_valid = pix_valid && pos_ok;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (pix_valid) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    win_d[r*KERNEL + c] = win_q[r*KERNEL + c + 1];
                end
                win_d[r*KERNEL + KERNEL - 1] = col_in[r];
            end
        end
    end

    // Output is packed from the next-state window so the strobe lands one cycle after the pixel.
    always_comb begin
        data2conv_d  = data2conv_q;
        en_out_d     = win_valid;
        frame_done_d = win_valid && row_last && col_last;
        if (win_valid) begin
            for (int i = 0; i < CL_IN; i++) begin
                for (int t = 0; t < KK; t++) begin
                    data2conv_d[tap_offset(i, t / KERNEL, t % KERNEL, KERNEL, N) +: N] =
                        win_d[t][i*N +: N];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            data2conv_q  <= '0;
            en_out_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            data2conv_q  <= data2conv_d;
            en_out_q     <= en_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign data2conv  = data2conv_q;
    assign en_out     = en_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - randomized check of conv_window_gen against a frame-array window model
module tb_conv_window_gen;

    logic clk;
    logic rst;

    logic         pv_a, pv_b, pv_c;
    logic [7:0]   px_a, px_c;
    logic [15:0]  px_b;
    logic [71:0]  d_a;
    logic [15:0]  d_b;
    logic [199:0] d_c;
    logic         en_a, en_b, en_c, fd_a, fd_b, fd_c;

    conv_window_gen #(.CL_IN(1), .KERNEL(3), .N(8), .IMG_W(4), .IMG_H(4)) u_a (
        .clk(clk), .rst(rst), .pix_in(px_a), .pix_valid(pv_a),
        .data2conv(d_a), .en_out(en_a), .frame_done(fd_a));

    conv_window_gen #(.CL_IN(2), .KERNEL(1), .N(8), .IMG_W(4), .IMG_H(4)) u_b (
        .clk(clk), .rst(rst), .pix_in(px_b), .pix_valid(pv_b),
        .data2conv(d_b), .en_out(en_b), .frame_done(fd_b));

    conv_window_gen #(.CL_IN(1), .KERNEL(5), .N(8), .IMG_W(5), .IMG_H(5)) u_c (
        .clk(clk), .rst(rst), .pix_in(px_c), .pix_valid(pv_c),
        .data2conv(d_c), .en_out(en_c), .frame_done(fd_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int strobes;
    int sel, mk, mw, mh, mcl;
    int m_row, m_col;
    logic [15:0] img [0:15][0:15];

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        pv_a = 1'b1;
        px_a = 8'hee;
        pv_b = 1'b0;
        pv_c = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        pv_a = 1'b0;
        check("rst_en_a", 200'(en_a), 200'd0);
        check("rst_fd_a", 200'(fd_a), 200'd0);
        check("rst_d_a", 200'(d_a), 200'd0);
        check("rst_en_b", 200'(en_b), 200'd0);
        check("rst_d_b", 200'(d_b), 200'd0);
        check("rst_en_c", 200'(en_c), 200'd0);
        check("rst_d_c", 200'(d_c), 200'd0);
        m_row = 0;
        m_col = 0;
    endtask

    task automatic select(input int s);
        sel = s;
        case (s)
            0:       begin mk = 3; mw = 4; mh = 4; mcl = 1; end
            1:       begin mk = 1; mw = 4; mh = 4; mcl = 2; end
            default: begin mk = 5; mw = 5; mh = 5; mcl = 1; end
        endcase
        do_reset();
    endtask

    // Expected window is read straight out of the accepted frame, tap (rr,cc) = pixel (row-K+1+rr, col-K+1+cc).
    task automatic step(input logic v, input logic [15:0] p);
        logic         exp_en, exp_fd, got_en, got_fd;
        logic [199:0] exp_d, got_d;
        exp_en = 1'b0;
        exp_fd = 1'b0;
        exp_d  = '0;
        pv_a = (sel == 0) && v;
        pv_b = (sel == 1) && v;
        pv_c = (sel == 2) && v;
        px_a = p[7:0];
        px_b = p;
        px_c = p[7:0];
        if (v) begin
            img[m_row][m_col] = p;
            if (m_row >= mk - 1 && m_col >= mk - 1) begin
                exp_en = 1'b1;
                exp_fd = (m_row == mh - 1) && (m_col == mw - 1);
                for (int ch = 0; ch < mcl; ch++)
                    for (int rr = 0; rr < mk; rr++)
                        for (int cc = 0; cc < mk; cc++)
                            exp_d[(ch*mk*mk + rr*mk + cc)*8 +: 8] =
                                img[m_row-mk+1+rr][m_col-mk+1+cc][ch*8 +: 8];
            end
            m_col++;
            if (m_col == mw) begin
                m_col = 0;
                m_row++;
                if (m_row == mh) m_row = 0;
            end
        end
        @(posedge clk);
        #1;
        pv_a = 1'b0;
        pv_b = 1'b0;
        pv_c = 1'b0;
        case (sel)
            0:       begin got_en = en_a; got_fd = fd_a; got_d = 200'(d_a); end
            1:       begin got_en = en_b; got_fd = fd_b; got_d = 200'(d_b); end
            default: begin got_en = en_c; got_fd = fd_c; got_d = d_c; end
        endcase
        if (got_en) strobes++;
        check("en_out", 200'(got_en), 200'(exp_en));
        if (exp_en) begin
            check("data2conv", got_d, exp_d);
            check("frame_done", 200'(got_fd), 200'(exp_fd));
        end
    endtask

    task automatic ramp_frame(input bit gaps);
        for (int r = 0; r < mh; r++) begin
            for (int c = 0; c < mw; c++) begin
                while (gaps && $urandom_range(0, 2) == 0) step(1'b0, 16'($urandom));
                step(1'b1, 16'(r * 16 + c));
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        pv_a = 1'b0; pv_b = 1'b0; pv_c = 1'b0;
        px_a = '0;   px_b = '0;   px_c = '0;

        select(0);
        strobes = 0;
        ramp_frame(1'b0);
        check("a_strobe_count", 200'(strobes), 200'd4);

        select(0);
        ramp_frame(1'b1);

        select(0);
        strobes = 0;
        ramp_frame(1'b0);
        ramp_frame(1'b0);
        check("a_two_frame_count", 200'(strobes), 200'd8);

        select(0);
        for (int i = 0; i < 10; i++) step(1'b1, 16'((i / 4) * 16 + (i % 4)));
        select(0);
        ramp_frame(1'b0);

        select(0);
        for (int i = 0; i < 32; i++) begin
            while ($urandom_range(0, 3) == 0) step(1'b0, 16'($urandom));
            step(1'b1, 16'($urandom_range(0, 255)));
        end

        select(1);
        for (int i = 0; i < 32; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) step(1'b0, 16'($urandom));
            step(1'b1, {~b, b});
        end

        select(2);
        strobes = 0;
        ramp_frame(1'b0);
        check("c_strobe_count", 200'(strobes), 200'd1);
        check("c_tap24", 200'(d_c[24*8 +: 8]), 200'h44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
